// File: rtl/wimax_deinterleaver_if.sv
`default_nettype none
// ============================================================================
//  Module      : wimax_deinterleaver_if
//  Description : Serial bit-stream handshake bundle for the WiMAX deinterleaver
//  Revision    : 1.0 - initial release
// ============================================================================
interface wimax_deinterleaver_if;
  logic in_valid;
  logic in_data;
  logic in_ready;
  logic out_valid;
  logic out_data;
  logic out_ready;
  logic out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface
`default_nettype wire

// File: rtl/wimax_deinterleaver.sv
`default_nettype none
// ============================================================================
//  Module      : wimax_deinterleaver
//  Description : Ping-pong block deinterleaver (802.16 two-step permutation)
//  Revision    : 1.0 - initial release
// ============================================================================
module wimax_deinterleaver #(
  parameter int NCBPS = 192,
  parameter int NCPC  = 2,
  parameter int D     = 16
) (
  input  logic                clock,
  input  logic                reset,
  wimax_deinterleaver_if.slave bus
);

  localparam int S  = (NCPC >= 4) ? 2 : 1;
  localparam int R  = NCBPS / D;
  localparam int AW = $clog2(NCBPS);

  localparam logic [AW-1:0] c_LAST     = AW'(NCBPS - 1);
  localparam logic [AW-1:0] c_COL_LAST = AW'(R - 1);
  localparam logic [AW-1:0] c_D        = AW'(D);
  localparam logic [AW-1:0] c_ONE      = AW'(1);

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_FILLING  = 2'd1,
    ST_FULL     = 2'd2,
    ST_DRAINING = 2'd3
  } bank_state_t;

  bank_state_t      r_state     [2];
  bank_state_t      w_state_nxt [2];
  logic [NCBPS-1:0] r_mem       [2];
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [AW-1:0]    r_wr_cnt;
  logic [AW-1:0]    r_col;
  logic [AW-1:0]    r_row;
  logic [AW-1:0]    r_col_base;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    w_wr_addr;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_xfer;
  logic             w_wr_last;
  logic             w_rd_last;

  assign w_in_ready  = (r_state[r_wr_bank] == ST_EMPTY) || (r_state[r_wr_bank] == ST_FILLING);
  assign w_out_valid = (r_state[r_rd_bank] == ST_FULL)  || (r_state[r_rd_bank] == ST_DRAINING);
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_xfer      = w_out_valid & bus.out_ready;
  assign w_wr_last   = (r_wr_cnt == c_LAST);
  assign w_rd_last   = (r_rd_ptr == c_LAST);

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_valid & r_mem[r_rd_bank][r_rd_ptr];
  assign bus.out_last  = w_out_valid & w_rd_last;

  // k = D*col + row, with D*col carried as a running sum so no multiplier is built
  generate
    if (S == 2) begin : g_pair_swap
      // Odd rows swap the two bits of each carrier pair (m LSB = j LSB ^ row LSB)
      always_comb begin
        w_wr_addr = r_col_base + r_row;
        if (r_row[0]) begin
          if (r_col[0]) w_wr_addr = r_col_base - c_D + r_row;
          else          w_wr_addr = r_col_base + c_D + r_row;
        end
      end
    end else begin : g_no_swap
      assign w_wr_addr = r_col_base + r_row;
    end
  endgenerate

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_state_nxt[b] = r_state[b];
      if (w_accept && (r_wr_bank == 1'(b)))
        w_state_nxt[b] = w_wr_last ? ST_FULL : ST_FILLING;
      if (w_xfer && (r_rd_bank == 1'(b)))
        w_state_nxt[b] = w_rd_last ? ST_EMPTY : ST_DRAINING;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state[0] <= ST_EMPTY;
      r_state[1] <= ST_EMPTY;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_wr_cnt   <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_col_base <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_state[0] <= w_state_nxt[0];
      r_state[1] <= w_state_nxt[1];
      if (w_accept) begin
        if (w_wr_last) begin
          r_wr_cnt   <= '0;
          r_col      <= '0;
          r_row      <= '0;
          r_col_base <= '0;
          r_wr_bank  <= ~r_wr_bank;
        end else begin
          r_wr_cnt <= r_wr_cnt + c_ONE;
          if (r_col == c_COL_LAST) begin
            r_col      <= '0;
            r_col_base <= '0;
            r_row      <= r_row + c_ONE;
          end else begin
            r_col      <= r_col + c_ONE;
            r_col_base <= r_col_base + c_D;
          end
        end
      end
      if (w_xfer) begin
        r_rd_ptr <= w_rd_last ? '0 : r_rd_ptr + c_ONE;
        if (w_rd_last) r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  // Bank storage needs no reset: readout is gated by the bank state
  always_ff @(posedge clock) begin
    if (w_accept) r_mem[r_wr_bank][w_wr_addr] <= bus.in_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_wimax_deinterleaver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wimax_deinterleaver
//  Description : Self-checking bench with a formula-level deinterleave model
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wimax_deinterleaver;

  localparam int NCBPS = 192;
  localparam int NCPC  = 2;
  localparam int D     = 16;
  localparam int S_TB  = (NCPC / 2 > 1) ? NCPC / 2 : 1;

  localparam logic [191:0] c_GOLD_IN  = 192'h4B04_7DFA_42F2_A5D5_F61C_021A_5851_E9A3_09A2_4FD5_8086_BD1E;
  localparam logic [191:0] c_GOLD_OUT = 192'h2833_E48D_3920_26D5_B6DC_5E4A_F47A_DD29_494B_6C89_1513_48CA;

  logic clock;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   or_mode;
  int   vcnt;
  int   nrdy_cnt;
  int   in_cnt;
  bit   blk [NCBPS];
  bit   ob  [NCBPS];
  logic [1:0] exp_q [$];
  bit   cap_q [$];
  logic prev_stall;
  logic prev_data;
  logic prev_last;

  wimax_deinterleaver_if bus ();

  wimax_deinterleaver #(.NCBPS(NCBPS), .NCPC(NCPC), .D(D)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  // Interleaved index j -> natural index k, straight from the two permutation formulas
  function automatic int ref_k(input int j);
    int m;
    m = S_TB * (j / S_TB) + (j + (D * j) / NCBPS) % S_TB;
    return D * m - (NCBPS - 1) * ((D * m) / NCBPS);
  endfunction

  function automatic logic [191:0] rand_blk();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [191:0] cap_vec();
    logic [191:0] v;
    v = '0;
    for (int i = 0; i < NCBPS; i++) v[191-i] = (i < cap_q.size()) ? cap_q[i] : 1'b0;
    return v;
  endfunction

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (or_mode)
        0:       bus.out_ready = 1'b0;
        2:       bus.out_ready = 1'($urandom_range(1));
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      in_cnt = 0;
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready vs model", bus.in_ready, exp_q.size() <= NCBPS);
      chk("out_valid vs model", bus.out_valid, exp_q.size() != 0);
      if (prev_stall) begin
        chk("out_data held in stall", bus.out_data, prev_data);
        chk("out_last held in stall", bus.out_last, prev_last);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
      if (bus.out_valid)  vcnt++;
      if (!bus.in_ready)  nrdy_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        logic [1:0] e;
        cap_q.push_back(bus.out_data);
        if (exp_q.size() == 0) begin
          chk("output while model empty", bus.out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", bus.out_data, e[0]);
          chk("out_last", bus.out_last, e[1]);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        blk[in_cnt] = bus.in_data;
        in_cnt++;
        if (in_cnt == NCBPS) begin
          for (int j = 0; j < NCBPS; j++) ob[ref_k(j)] = blk[j];
          for (int k = 0; k < NCBPS; k++) exp_q.push_back({k == NCBPS - 1, ob[k]});
          in_cnt = 0;
        end
      end
    end
  end

  task automatic send_bit(input logic b, input int pct);
    logic acc;
    for (int g = 0; g < 10000; g++) begin
      bus.in_valid = (int'($urandom_range(99)) < pct);
      bus.in_data  = b;
      acc = bus.in_valid && bus.in_ready;
      @(posedge clock);
      #1;
      if (acc) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL input accept timeout: in_ready %0b, required 1", bus.in_ready);
  endtask

  task automatic send_block(input logic [191:0] v, input int pct);
    for (int j = 0; j < NCBPS; j++) send_bit(v[191-j], pct);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_cap(input int n);
    for (int g = 0; g < 20000; g++) begin
      if (cap_q.size() >= n) return;
      @(posedge clock);
      #2;
    end
    chk("output count timeout", cap_q.size(), n);
  endtask

  task automatic wait_drain();
    for (int g = 0; g < 20000; g++) begin
      if (exp_q.size() == 0 && !bus.out_valid) return;
      @(posedge clock);
      #2;
    end
    chk("drain timeout", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    int wj [4];
    int wk [4];
    logic [191:0] v;
    logic [191:0] e;
    wj = '{13, 0, 191, 12};
    wk = '{17, 0, 191, 1};
    reset        = 1'b1;
    or_mode      = 1;
    bus.in_valid = 1'b0;
    bus.in_data  = 1'b0;
    vcnt = 0;
    nrdy_cnt = 0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("reset out_valid", bus.out_valid, 1'b0);
    chk("reset out_data",  bus.out_data,  1'b0);
    chk("reset out_last",  bus.out_last,  1'b0);
    chk("reset in_ready",  bus.in_ready,  1'b1);

    for (int i = 0; i < 4; i++) chk("model k(j)", ref_k(wj[i]), wk[i]);

    // Golden vector
    cap_q.delete();
    send_block(c_GOLD_IN, 100);
    wait_cap(NCBPS);
    chk("golden output", cap_vec(), c_GOLD_OUT);

    // Single-one walk
    for (int i = 0; i < 4; i++) begin
      wait_drain();
      cap_q.delete();
      v = '0;
      v[191-wj[i]] = 1'b1;
      e = '0;
      e[191-wk[i]] = 1'b1;
      send_block(v, 100);
      wait_cap(NCBPS);
      chk("single-one walk", cap_vec(), e);
    end

    // Streaming, four blocks back to back
    wait_drain();
    vcnt = 0;
    nrdy_cnt = 0;
    for (int b = 0; b < 4; b++) send_block(rand_blk(), 100);
    wait_drain();
    chk("streaming out_valid cycles", vcnt, 4 * NCBPS);
    chk("streaming in_ready low cycles", nrdy_cnt, 0);

    // Backpressure
    or_mode = 0;
    cap_q.delete();
    send_block(rand_blk(), 100);
    send_block(rand_blk(), 100);
    #1;
    chk("in_ready after 384 accepts", bus.in_ready, 1'b0);
    repeat (20) @(posedge clock);
    #2;
    chk("in_ready held under backpressure", bus.in_ready, 1'b0);
    or_mode = 1;
    wait_drain();
    chk("backpressure output count", cap_q.size(), 2 * NCBPS);

    // Random gaps on both sides
    or_mode = 2;
    cap_q.delete();
    for (int b = 0; b < 20; b++) send_block(rand_blk(), 50);
    or_mode = 1;
    wait_drain();
    chk("random gaps output count", cap_q.size(), 20 * NCBPS);

    // Reset while block 1 drains and block 2 fills
    send_block(rand_blk(), 100);
    v = rand_blk();
    for (int j = 0; j < 100; j++) send_bit(v[191-j], 100);
    bus.in_valid = 1'b0;
    do_reset();
    chk("post-reset out_valid", bus.out_valid, 1'b0);
    chk("post-reset in_ready",  bus.in_ready,  1'b1);
    cap_q.delete();
    send_block(c_GOLD_IN, 100);
    wait_cap(NCBPS);
    chk("golden after reset", cap_vec(), c_GOLD_OUT);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
